// File: rtl/taus_pkg.sv
// Purpose : shared types, seed limits and the combinational taus88 step.
// Latency : pure combinational helpers, no state.
// Backpressure: n/a (no handshake in this file).
//
// Contents:
//   MIN_S1..MIN_S3   smallest legal seed per component (smaller seeds degenerate)
//   MASK_S1..MASK_S3 low-bit masks applied before the long shift of each component
//   gen_state_e      pair-assembly FSM states
//   taus_state_t     the three 32-bit component states
//   taus_step_t      next component states plus the combined output word
//   taus88_step()    one generator step
//   seed_below_min() true when a seed must be replaced by its default
package taus_pkg;

   // A component seed below its minimum leaves only the masked-off low bits
   // set, which collapses that component to an all-zero sequence.
   localparam logic [31:0] MIN_S1 = 32'd2;
   localparam logic [31:0] MIN_S2 = 32'd8;
   localparam logic [31:0] MIN_S3 = 32'd16;

   localparam logic [31:0] MASK_S1 = ~32'd1;
   localparam logic [31:0] MASK_S2 = ~32'd7;
   localparam logic [31:0] MASK_S3 = ~32'd15;

   // GEN_LO produces the first word of a pair; GEN_HI the second word
   // together with the load of the output stage.
   typedef enum logic {
      GEN_LO = 1'b0,
      GEN_HI = 1'b1
   } gen_state_e;

   typedef struct packed {
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] s3;
   } taus_state_t;

   typedef struct packed {
      taus_state_t s;
      logic [31:0] word;
   } taus_step_t;

   // One taus88 step. All shifts truncate to 32 bits. The output word is
   // built from the updated states, not the current ones.
   function automatic taus_step_t taus88_step(input taus_state_t cur);
      logic [31:0] b1;
      logic [31:0] b2;
      logic [31:0] b3;
      taus_step_t  nxt;
      b1         = ((cur.s1 << 13) ^ cur.s1) >> 19;
      nxt.s.s1   = ((cur.s1 & MASK_S1) << 12) ^ b1;
      b2         = ((cur.s2 << 2) ^ cur.s2) >> 25;
      nxt.s.s2   = ((cur.s2 & MASK_S2) << 4) ^ b2;
      b3         = ((cur.s3 << 3) ^ cur.s3) >> 11;
      nxt.s.s3   = ((cur.s3 & MASK_S3) << 17) ^ b3;
      nxt.word   = nxt.s.s1 ^ nxt.s.s2 ^ nxt.s.s3;
      return nxt;
   endfunction

   function automatic logic seed_below_min(input logic [31:0] seed,
                                           input logic [31:0] min_seed);
      return (seed < min_seed);
   endfunction

endpackage

// File: rtl/taus88_core.sv
// Purpose : taus88 state registers with seed load/sanitize and step enable.
// Latency : word_o is the combinational next word; states update on the step edge.
// Backpressure: states hold whenever step_en_i is low.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (restores defaults)
//   load_i          load seed1_i..seed3_i (priority over step_en_i)
//   seed1_i..3_i    candidate seeds, replaced by defaults when below minimum
//   step_en_i       advance all three components by one step
//   word_o          word that the next step will produce
//   seed_err_o      some seed was replaced at the most recent load
module taus88_core
   import taus_pkg::*;
#(
   parameter logic [31:0] DEFAULT_S1 = 32'h0000_1234,
   parameter logic [31:0] DEFAULT_S2 = 32'h0000_5678,
   parameter logic [31:0] DEFAULT_S3 = 32'h0009_ABCD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [31:0] seed1_i,
   input  logic [31:0] seed2_i,
   input  logic [31:0] seed3_i,
   input  logic        step_en_i,
   output logic [31:0] word_o,
   output logic        seed_err_o
);

   taus_state_t state_q;
   taus_state_t state_d;
   logic        seed_err_q;
   logic        seed_err_d;
   taus_step_t  nxt;

   logic        sub1;
   logic        sub2;
   logic        sub3;

   assign nxt  = taus88_step(state_q);
   assign sub1 = seed_below_min(seed1_i, MIN_S1);
   assign sub2 = seed_below_min(seed2_i, MIN_S2);
   assign sub3 = seed_below_min(seed3_i, MIN_S3);

   always_comb begin
      state_d    = state_q;
      seed_err_d = seed_err_q;
      if (load_i) begin
         state_d.s1 = sub1 ? DEFAULT_S1 : seed1_i;
         state_d.s2 = sub2 ? DEFAULT_S2 : seed2_i;
         state_d.s3 = sub3 ? DEFAULT_S3 : seed3_i;
         // The flag reflects only the latest load, so a clean load clears it.
         seed_err_d = sub1 | sub2 | sub3;
      end else if (step_en_i) begin
         state_d = nxt.s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q.s1 <= DEFAULT_S1;
         state_q.s2 <= DEFAULT_S2;
         state_q.s3 <= DEFAULT_S3;
         seed_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seed_err_q <= seed_err_d;
      end
   end

   assign word_o     = nxt.word;
   assign seed_err_o = seed_err_q;

endmodule

// File: rtl/taus_pair_urng.sv
// Purpose : packs two consecutive taus88 words into a (u1, u2) pair on valid/ready.
// Latency : first pair valid 2 cycles after reset release or seed_load; 1 pair / 2 cycles.
// Backpressure: a held pair stalls the generator in GEN_HI; no word is skipped or repeated.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   seed_load        one-cycle pulse loading seed1..seed3 (rst has priority)
//   seed1..seed3     component seeds
//   seed_err         a seed was replaced by its default at the last seed_load
//   out_valid        u1/u2 hold a pair
//   out_ready        consumer accepts the pair
//   u1, u2           first and second word of the pair
module taus_pair_urng
   import taus_pkg::*;
#(
   parameter logic [31:0] DEFAULT_S1 = 32'h0000_1234,
   parameter logic [31:0] DEFAULT_S2 = 32'h0000_5678,
   parameter logic [31:0] DEFAULT_S3 = 32'h0009_ABCD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_load,
   input  logic [31:0] seed1,
   input  logic [31:0] seed2,
   input  logic [31:0] seed3,
   output logic        seed_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] u1,
   output logic [31:0] u2
);

   gen_state_e  state_q;
   logic [31:0] lo_q;
   logic [31:0] u1_q;
   logic [31:0] u2_q;
   logic        out_valid_q;

   logic        handshake;
   logic        step_en;
   logic        pair_load;
   logic [31:0] word;

   assign handshake = out_valid_q && out_ready;

   // GEN_LO always steps (lo_q is free). GEN_HI steps only when the output
   // stage can take the new pair: empty, or drained this very cycle.
   // A seed_load overrides the step; the core gives its load priority too.
   assign step_en   = !seed_load &&
                      ((state_q == GEN_LO) || !out_valid_q || out_ready);
   assign pair_load = (state_q == GEN_HI) && step_en;

   taus88_core #(
      .DEFAULT_S1 (DEFAULT_S1),
      .DEFAULT_S2 (DEFAULT_S2),
      .DEFAULT_S3 (DEFAULT_S3)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .load_i     (seed_load),
      .seed1_i    (seed1),
      .seed2_i    (seed2),
      .seed3_i    (seed3),
      .step_en_i  (step_en),
      .word_o     (word),
      .seed_err_o (seed_err)
   );

   // Pair-assembly FSM and output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= GEN_LO;
         lo_q        <= '0;
         u1_q        <= '0;
         u2_q        <= '0;
         out_valid_q <= 1'b0;
      end else if (seed_load) begin
         // Any half-built pair belongs to the old sequence and is dropped.
         // A handshake in this cycle still completed on the consumer side.
         state_q     <= GEN_LO;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (handshake) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            GEN_LO: begin
               lo_q    <= word;
               state_q <= GEN_HI;
            end
            GEN_HI: begin
               if (pair_load) begin
                  // Reload wins over the handshake clear above.
                  u1_q        <= lo_q;
                  u2_q        <= word;
                  out_valid_q <= 1'b1;
                  state_q     <= GEN_LO;
               end
            end
            default: state_q <= GEN_LO;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign u1        = u1_q;
   assign u2        = u2_q;

endmodule

// File: tb/tb_taus_pair_urng.sv
module tb_taus_pair_urng;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_load;
   logic [31:0] seed1;
   logic [31:0] seed2;
   logic [31:0] seed3;
   logic        seed_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] u1;
   logic [31:0] u2;

   always #5 clk = ~clk;

   taus_pair_urng dut (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed1     (seed1),
      .seed2     (seed2),
      .seed3     (seed3),
      .seed_err  (seed_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .u1        (u1),
      .u2        (u2)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;

   pair_t exp_q[$];
   int    n_cmp   = 0;
   int    n_err   = 0;
   int    n_pairs = 0;

   // Reference generator: each taus88 component as a table row
   // {left shift, right shift, long shift, minimum seed}.
   localparam int          QS[3]   = '{13, 2, 3};
   localparam int          RS[3]   = '{19, 25, 11};
   localparam int          LS[3]   = '{12, 4, 17};
   localparam logic [31:0] MINV[3] = '{32'd2, 32'd8, 32'd16};
   localparam logic [31:0] DEF[3]  = '{32'h0000_1234, 32'h0000_5678, 32'h0009_ABCD};
   logic [31:0] m_s[3];

   function automatic logic [31:0] model_word();
      logic [31:0] w = '0;
      logic [31:0] s;
      logic [31:0] b;
      for (int i = 0; i < 3; i++) begin
         s      = m_s[i];
         b      = ((s << QS[i]) ^ s) >> RS[i];
         s      = ((s & ~(MINV[i] - 32'd1)) << LS[i]) ^ b;
         m_s[i] = s;
         w      = w ^ s;
      end
      return w;
   endfunction

   task automatic topup();
      pair_t p;
      while (exp_q.size() < 8) begin
         p.a = model_word();
         p.b = model_word();
         exp_q.push_back(p);
      end
   endtask

   task automatic model_seed(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, output logic err);
      logic [31:0] sd[3];
      sd[0] = a; sd[1] = b; sd[2] = c;
      err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (sd[i] < MINV[i]) begin
            m_s[i] = DEF[i];
            err    = 1'b1;
         end else begin
            m_s[i] = sd[i];
         end
      end
      exp_q.delete();
      topup();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      topup();
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      logic e;
      seed1     = a;
      seed2     = b;
      seed3     = c;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      model_seed(a, b, c, e);
      check("seed_err_after_load", {31'b0, seed_err}, {31'b0, e});
      check("valid_cleared_by_load", {31'b0, out_valid}, 32'd0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check("wait_valid_timeout", {31'b0, out_valid}, 32'd1);
   endtask

   // Monitor: pops on every handshake, and checks that a refused pair is
   // still presented unchanged on the following cycle.
   initial begin
      logic        pv  = 1'b0;
      logic        pr  = 1'b0;
      logic        pev = 1'b1;
      logic [31:0] pu1 = '0;
      logic [31:0] pu2 = '0;
      pair_t       p;
      forever begin
         @(negedge clk);
         if (pv && !pr && !pev) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_u1", u1, pu1);
            check("hold_u2", u2, pu2);
         end
         if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL pair_underflow: got u1=%h u2=%h expected no pair", u1, u2);
            end else begin
               p = exp_q.pop_front();
               check("pair_u1", u1, p.a);
               check("pair_u2", u2, p.b);
               n_pairs++;
            end
         end
         pv  = out_valid;
         pr  = out_ready;
         pev = rst | seed_load;
         pu1 = u1;
         pu2 = u2;
      end
   end

   initial begin
      logic e;
      int   base;
      int   cyc;
      rst       = 1'b1;
      seed_load = 1'b0;
      seed1     = '0;
      seed2     = '0;
      seed3     = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_u1", u1, 32'd0);
      check("rst_u2", u2, 32'd0);
      check("rst_seed_err", {31'b0, seed_err}, 32'd0);

      // Reset release latency and default-seed stream.
      rst       = 1'b0;
      out_ready = 1'b1;
      model_seed(DEF[0], DEF[1], DEF[2], e);
      tick();
      check("lat_rst_1", {31'b0, out_valid}, 32'd0);
      tick();
      check("lat_rst_2", {31'b0, out_valid}, 32'd1);
      repeat (6) tick();

      // Minimum seeds, ready held high: known first pair and 1,0,1,0 cadence.
      do_load(32'd2, 32'd8, 32'd16);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check("cadence", {31'b0, out_valid}, {31'b0, (k >= 2) && (k % 2 == 0)});
         if (k == 2) begin
            check("first_u1", u1, 32'h0020_2080);
            check("first_u2", u2, 32'h0200_2C80);
         end
      end

      // Seed substitution and its clearing.
      do_load(32'd0, 32'd8, 32'd16);
      repeat (8) tick();
      do_load(32'd5, 32'd9, 32'd17);
      repeat (6) tick();
      do_load(32'd3, 32'd7, 32'd100);
      repeat (6) tick();

      // Ten-cycle stall on the first pair of 2/8/16.
      out_ready = 1'b0;
      do_load(32'd2, 32'd8, 32'd16);
      tick();
      tick();
      for (int k = 0; k < 10; k++) begin
         check("stall_valid", {31'b0, out_valid}, 32'd1);
         check("stall_u1", u1, 32'h0020_2080);
         check("stall_u2", u2, 32'h0200_2C80);
         tick();
      end
      out_ready = 1'b1;
      repeat (20) tick();

      // seed_load in a handshake cycle: the pair still transfers.
      wait_valid();
      base = n_pairs;
      do_load($urandom, $urandom, $urandom);
      check("load_hs_counted", n_pairs, base + 1);
      tick();
      check("load_hs_lat1", {31'b0, out_valid}, 32'd0);
      tick();
      check("load_hs_lat2", {31'b0, out_valid}, 32'd1);

      // Random backpressure over 1000 pairs.
      base = n_pairs;
      cyc  = 0;
      while (n_pairs < base + 1000 && cyc < 20000) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      check("random_pairs_done", n_pairs - base >= 1000, 32'd1);

      // Reset while stalled in GEN_HI with a pair presented.
      out_ready = 1'b1;
      do_load(32'd0, 32'd0, 32'd0);
      out_ready = 1'b0;
      wait_valid();
      tick();
      check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_u1", u1, 32'd0);
      check("mid_rst_u2", u2, 32'd0);
      check("mid_rst_seed_err", {31'b0, seed_err}, 32'd0);
      model_seed(DEF[0], DEF[1], DEF[2], e);
      out_ready = 1'b1;
      tick();
      check("mid_rst_lat1", {31'b0, out_valid}, 32'd0);
      tick();
      check("mid_rst_lat2", {31'b0, out_valid}, 32'd1);
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
